// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default widths, control-bundle bit map and the bubble encoding.
package mips_pkg;

    localparam int unsigned AWL = 5;
    localparam int unsigned DWL = 32;
    localparam int unsigned CTW = 9;
    localparam int unsigned SCW = 16;

    localparam int unsigned REG_WRITE    = 0;
    localparam int unsigned MEM_TO_REG   = 1;
    localparam int unsigned MEM_WRITE    = 2;
    localparam int unsigned MEM_READ     = 3;
    localparam int unsigned ALU_SRC      = 4;
    localparam int unsigned REG_DST      = 5;
    localparam int unsigned ALU_CTRL_LSB = 6;
    localparam int unsigned ALU_CTRL_MSB = 8;

    localparam logic [CTW-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bundle: decoded ID inputs, WB write-back snoop and the registered EX view.
interface id_ex_stage_if
    import mips_pkg::*;
#(
    parameter int unsigned AWL = mips_pkg::AWL,
    parameter int unsigned DWL = mips_pkg::DWL,
    parameter int unsigned CTW = mips_pkg::CTW,
    parameter int unsigned SCW = mips_pkg::SCW
);
    logic           id_valid_i;
    logic [DWL-1:0] rs_data_i;
    logic [DWL-1:0] rt_data_i;
    logic [15:0]    imm_i;
    logic [AWL-1:0] rs_i;
    logic [AWL-1:0] rt_i;
    logic [AWL-1:0] rd_i;
    logic           uses_rt_i;
    logic [CTW-1:0] ctrl_i;
    logic           stall_i;
    logic           flush_i;
    logic           wb_we_i;
    logic [AWL-1:0] wb_addr_i;
    logic [DWL-1:0] wb_data_i;

    logic           ex_valid_o;
    logic [DWL-1:0] ex_rs_data_o;
    logic [DWL-1:0] ex_rt_data_o;
    logic [DWL-1:0] ex_imm_o;
    logic [AWL-1:0] ex_rs_o;
    logic [AWL-1:0] ex_rt_o;
    logic [AWL-1:0] ex_rd_o;
    logic [CTW-1:0] ex_ctrl_o;
    logic           hazard_o;
    logic [SCW-1:0] stall_cnt_o;

    modport slave (
        input  id_valid_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i, uses_rt_i,
               ctrl_i, stall_i, flush_i, wb_we_i, wb_addr_i, wb_data_i,
        output ex_valid_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o,
               ex_rd_o, ex_ctrl_o, hazard_o, stall_cnt_o
    );

    modport master (
        output id_valid_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i, uses_rt_i,
               ctrl_i, stall_i, flush_i, wb_we_i, wb_addr_i, wb_data_i,
        input  ex_valid_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o,
               ex_rd_o, ex_ctrl_o, hazard_o, stall_cnt_o
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detector: an EX-stage load whose destination is read by the instruction in ID.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int unsigned AWL = mips_pkg::AWL
) (
    input  logic           id_valid_i,
    input  logic           ex_valid_i,
    input  logic           ex_mem_read_i,
    input  logic [AWL-1:0] ex_rt_i,
    input  logic [AWL-1:0] rs_i,
    input  logic [AWL-1:0] rt_i,
    input  logic           uses_rt_i,
    output logic           ld_use_o
);

    logic rs_match;
    logic rt_match;

    // $0 is hard-wired, so a load targeting it can never create a dependency
    assign rs_match = (ex_rt_i == rs_i);
    assign rt_match = uses_rt_i && (ex_rt_i == rt_i);
    assign ld_use_o = id_valid_i && ex_valid_i && ex_mem_read_i &&
                      (ex_rt_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
// Define RF_WB_BYPASS_EN to forward same-cycle WB writes into the captured operands.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned AWL = mips_pkg::AWL,
    parameter int unsigned DWL = mips_pkg::DWL,
    parameter int unsigned CTW = mips_pkg::CTW,
    parameter int unsigned SCW = mips_pkg::SCW
) (
    input  logic          CLK,
    input  logic          RST,
    id_ex_stage_if.slave  bus
);

    logic           ex_valid_q,   ex_valid_d;
    logic [DWL-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DWL-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [DWL-1:0] ex_imm_q,     ex_imm_d;
    logic [AWL-1:0] ex_rs_q,      ex_rs_d;
    logic [AWL-1:0] ex_rt_q,      ex_rt_d;
    logic [AWL-1:0] ex_rd_q,      ex_rd_d;
    logic [CTW-1:0] ex_ctrl_q,    ex_ctrl_d;
    logic [SCW-1:0] stall_cnt_q,  stall_cnt_d;

    logic           ld_use;
    logic [DWL-1:0] rs_fwd;
    logic [DWL-1:0] rt_fwd;
    logic [DWL-1:0] imm_ext;

    hazard_detect #(.AWL(AWL)) u_hazard_detect (
        .id_valid_i    (bus.id_valid_i),
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (ex_ctrl_q[MEM_READ]),
        .ex_rt_i       (ex_rt_q),
        .rs_i          (bus.rs_i),
        .rt_i          (bus.rt_i),
        .uses_rt_i     (bus.uses_rt_i),
        .ld_use_o      (ld_use)
    );

`ifdef RF_WB_BYPASS_EN
    // Covers the RF write-then-read race when WB and ID touch the same register
    assign rs_fwd = (bus.wb_we_i && (bus.wb_addr_i != '0) && (bus.wb_addr_i == bus.rs_i))
                    ? bus.wb_data_i : bus.rs_data_i;
    assign rt_fwd = (bus.wb_we_i && (bus.wb_addr_i != '0) && (bus.wb_addr_i == bus.rt_i))
                    ? bus.wb_data_i : bus.rt_data_i;
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_we_i, bus.wb_addr_i, bus.wb_data_i};
    assign rs_fwd    = bus.rs_data_i;
    assign rt_fwd    = bus.rt_data_i;
`endif

    assign imm_ext = {{(DWL-16){bus.imm_i[15]}}, bus.imm_i};

    // Next state: flush > stall > load-use bubble > capture
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rt_data_d = ex_rt_data_q;
        ex_imm_d     = ex_imm_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_rd_d      = ex_rd_q;
        ex_ctrl_d    = ex_ctrl_q;
        stall_cnt_d  = stall_cnt_q;

        if (bus.flush_i || (!bus.stall_i && ld_use)) begin
            ex_valid_d   = 1'b0;
            ex_rs_data_d = '0;
            ex_rt_data_d = '0;
            ex_imm_d     = '0;
            ex_rs_d      = '0;
            ex_rt_d      = '0;
            ex_rd_d      = '0;
            ex_ctrl_d    = CTW'(BUBBLE_CTRL);
            if (!bus.flush_i && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + SCW'(1);
            end
        end else if (!bus.stall_i) begin
            ex_valid_d   = bus.id_valid_i;
            ex_rs_data_d = rs_fwd;
            ex_rt_data_d = rt_fwd;
            ex_imm_d     = imm_ext;
            ex_rs_d      = bus.rs_i;
            ex_rt_d      = bus.rt_i;
            ex_rd_d      = bus.rd_i;
            ex_ctrl_d    = bus.id_valid_i ? bus.ctrl_i : CTW'(BUBBLE_CTRL);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid_q   <= 1'b0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_ctrl_q    <= '0;
            stall_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_ctrl_q    <= ex_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.ex_valid_o   = ex_valid_q;
    assign bus.ex_rs_data_o = ex_rs_data_q;
    assign bus.ex_rt_data_o = ex_rt_data_q;
    assign bus.ex_imm_o     = ex_imm_q;
    assign bus.ex_rs_o      = ex_rs_q;
    assign bus.ex_rt_o      = ex_rt_q;
    assign bus.ex_rd_o      = ex_rd_q;
    assign bus.ex_ctrl_o    = ex_ctrl_q;
    assign bus.hazard_o     = ld_use;
    assign bus.stall_cnt_o  = stall_cnt_q;

endmodule
